// File: rtl/sym_fir_pkg.sv
// -----------------------------------------------------------------------------
// sym_fir_pkg
//   Shared definitions for the time-multiplexed symmetric FIR stage.
//   - Fixed numeric formats: sample width, coefficient width (Q1.17) and the
//     matching result shift.
//   - Coefficient builders for the production set (triangular low-pass, unity
//     DC gain) and the test set (flat, DC gain 2). Only the first half of the
//     symmetric impulse response is produced; h[TAPS-1-k] = h[k] is implied.
//   - FSM state encoding and the round/saturate helper used at the output.
// -----------------------------------------------------------------------------
package sym_fir_pkg;

    localparam int FIR_TAPS_MAX = 128;
    localparam int FIR_DATA_WD  = 24;
    localparam int COEF_WD      = 18;
    localparam int COEF_FRAC    = 17;

    localparam int HALF_MAX     = FIR_TAPS_MAX / 2;

    // Half of unity in Q1.17: the half-coefficients of a unity-gain filter
    // must add up to this, since each is used twice.
    localparam int DC_HALF      = 1 << (COEF_FRAC - 1);

    // Widest accumulator any legal TAPS can need; the helper below works at
    // this width and the datapath sign-extends into it.
    localparam int ACC_MAX_WD   = FIR_DATA_WD + 1 + COEF_WD + $clog2(HALF_MAX);

    // Half-coefficient table, entry k = h[k]. Unused upper entries are zero.
    typedef logic [HALF_MAX-1:0][COEF_WD-1:0] coef_arr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        ROUND = 2'd2,
        OUT   = 2'd3
    } fsm_e;

    // Production set: triangular (Bartlett) weights rising towards the
    // centre tap, h[k] ~ (k+1). Integer division leaves a small shortfall;
    // it is added to the centre tap so the full response sums to exactly
    // 2^COEF_FRAC and a DC input comes out bit-exact.
    function automatic coef_arr_t coef_prod(input int taps);
        coef_arr_t h;
        int        half;
        int        wsum;
        int        total;
        int        v;
        int        last;
        h     = '0;
        half  = taps / 2;
        wsum  = half * (half + 1) / 2;
        total = 0;
        last  = 0;
        for (int k = 0; k < HALF_MAX; k++) begin
            if (k < half) begin
                v     = (DC_HALF * (k + 1)) / wsum;
                h[k]  = COEF_WD'(v);
                total = total + v;
                last  = v;
            end
        end
        h[half-1] = COEF_WD'(last + (DC_HALF - total));
        return h;
    endfunction

    // Test set: flat response, every tap 2^(COEF_FRAC+1)/TAPS, DC gain 2.
    // Used to drive the output saturation logic with legal full-scale input.
    function automatic coef_arr_t coef_test(input int taps);
        coef_arr_t h;
        h = '0;
        for (int k = 0; k < HALF_MAX; k++) begin
            if (k < taps / 2) begin
                h[k] = COEF_WD'((1 << (COEF_FRAC + 1)) / taps);
            end
        end
        return h;
    endfunction

    // Reference tables for the default 32-tap build.
    localparam coef_arr_t FIR_COEF_PROD = coef_prod(32);
    localparam coef_arr_t FIR_COEF_TEST = coef_test(32);

    // Round half up, arithmetic shift right by frac, clamp to the signed
    // FIR_DATA_WD range. One guard bit above the accumulator keeps the
    // rounding add from overflowing.
    function automatic logic [FIR_DATA_WD-1:0] sat_round(
        input logic signed [ACC_MAX_WD-1:0] acc,
        input int                           frac
    );
        logic signed [ACC_MAX_WD:0] half_lsb;
        logic signed [ACC_MAX_WD:0] sum;
        logic signed [ACC_MAX_WD:0] r;
        logic signed [ACC_MAX_WD:0] max_v;
        logic signed [ACC_MAX_WD:0] min_v;
        half_lsb = (ACC_MAX_WD + 1)'(1) <<< (frac - 1);
        sum      = $signed({acc[ACC_MAX_WD-1], acc}) + half_lsb;
        r        = sum >>> frac;
        max_v    = '0;
        max_v[FIR_DATA_WD-2:0] = '1;
        min_v    = '1;
        min_v[FIR_DATA_WD-2:0] = '0;
        if (r > max_v) begin
            return max_v[FIR_DATA_WD-1:0];
        end else if (r < min_v) begin
            return min_v[FIR_DATA_WD-1:0];
        end
        return r[FIR_DATA_WD-1:0];
    endfunction

endpackage

// File: rtl/sym_fir_coef_rom.sv
// -----------------------------------------------------------------------------
// sym_fir_coef_rom
//   Combinational half-coefficient lookup for the symmetric FIR.
//   The table is built at elaboration for the configured TAPS; COEF_SEL picks
//   the production (0) or the DC-gain-2 test (1) set.
//
//   Ports
//     k     in   log2(TAPS/2)  MAC step index, 0 .. TAPS/2-1
//     coef  out  COEF_WD       h[k], signed Q1.17
// -----------------------------------------------------------------------------
module sym_fir_coef_rom
    import sym_fir_pkg::*;
#(
    parameter int TAPS     = 32,
    parameter int COEF_SEL = 0
) (
    input  logic [$clog2(TAPS/2)-1:0] k,
    output logic signed [COEF_WD-1:0] coef
);

    localparam coef_arr_t TABLE = (COEF_SEL != 0) ? coef_test(TAPS) : coef_prod(TAPS);

    always_comb begin
        coef = $signed(TABLE[k]);
    end

endmodule

// File: rtl/sym_fir_serial.sv
// -----------------------------------------------------------------------------
// sym_fir_serial
//   Time-multiplexed symmetric FIR low-pass. One sample is accepted per
//   strobe into a circular delay line; mirrored taps are folded through a
//   pre-adder so only TAPS/2 multiply-accumulates are needed, one per clock.
//   The accumulator is then rounded (half up), shifted by COEF_FRAC and
//   saturated to DATA_WD bits.
//
//   Timing per sample, counting the accept cycle as 0:
//     1 .. TAPS/2   MAC     one folded tap pair per cycle
//     TAPS/2+1      ROUND   round/saturate, load data_o
//     TAPS/2+2      OUT     data_valid_o high, then back to IDLE
//   A new sample can be taken every TAPS/2+3 cycles.
//
//   Coefficient width and fraction are those of sym_fir_pkg (the tables are
//   stored in that format). DATA_WD must match FIR_DATA_WD since the output
//   helper is sized from it.
//
//   Ports
//     clk_i           in   1        system clock
//     rst_ni          in   1        asynchronous active-low reset
//     sample_i        in   DATA_WD  signed input sample
//     sample_valid_i  in   1        one-cycle accept strobe
//     data_o          out  DATA_WD  filtered sample, held until next result
//     data_valid_o    out  1        one-cycle pulse when data_o updates
//     busy_o          out  1        computation in progress
//     overrun_o       out  1        sticky: strobe arrived while busy
//     clr_overrun_i   in   1        synchronous clear of overrun_o
// -----------------------------------------------------------------------------
module sym_fir_serial
    import sym_fir_pkg::*;
#(
    parameter int TAPS     = 32,
    parameter int DATA_WD  = FIR_DATA_WD,
    parameter int COEF_SEL = 0
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [DATA_WD-1:0] sample_i,
    input  logic               sample_valid_i,
    output logic [DATA_WD-1:0] data_o,
    output logic               data_valid_o,
    output logic               busy_o,
    output logic               overrun_o,
    input  logic               clr_overrun_i
);

    localparam int HALF   = TAPS / 2;
    localparam int PW     = $clog2(TAPS);
    localparam int KW     = $clog2(HALF);
    localparam int PRE_WD = DATA_WD + 1;
    localparam int MUL_WD = PRE_WD + COEF_WD;
    localparam int ACC_WD = DATA_WD + 1 + COEF_WD + KW;

    // Circular delay line; TAPS is a power of two so pointer arithmetic
    // wraps mod TAPS for free.
    logic signed [DATA_WD-1:0] dline [TAPS];
    logic [PW-1:0]             wr_ptr;
    logic [PW-1:0]             base;      // slot of the newest sample
    logic [KW-1:0]             k;
    fsm_e                      state;
    logic signed [ACC_WD-1:0]  acc;

    logic [PW-1:0]             idx_new;
    logic [PW-1:0]             idx_old;
    logic signed [PRE_WD-1:0]  pre;
    logic signed [COEF_WD-1:0] coef;
    logic signed [MUL_WD-1:0]  prod;

    sym_fir_coef_rom #(
        .TAPS     (TAPS),
        .COEF_SEL (COEF_SEL)
    ) u_rom (
        .k    (k),
        .coef (coef)
    );

    // Step k pairs the sample k steps older than the newest (base-k) with
    // its mirror, TAPS-1-k steps older, which sits at base+1+k in the ring.
    always_comb begin
        idx_new = base - PW'(k);
        idx_old = base + PW'(k) + PW'(1);
        pre     = PRE_WD'(dline[idx_new]) + PRE_WD'(dline[idx_old]);
        prod    = MUL_WD'(pre) * MUL_WD'(coef);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < TAPS; i++) begin
                dline[i] <= '0;
            end
            wr_ptr       <= '0;
            base         <= '0;
            k            <= '0;
            acc          <= '0;
            state        <= IDLE;
            data_o       <= '0;
            data_valid_o <= 1'b0;
            busy_o       <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            data_valid_o <= 1'b0;

            // Set is written after clear so a same-cycle overrun wins.
            if (clr_overrun_i) begin
                overrun_o <= 1'b0;
            end
            // busy_o mirrors state != IDLE, so this covers the OUT cycle too.
            if (sample_valid_i && busy_o) begin
                overrun_o <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (sample_valid_i) begin
                        dline[wr_ptr] <= sample_i;
                        base          <= wr_ptr;
                        wr_ptr        <= wr_ptr + PW'(1);
                        k             <= '0;
                        acc           <= '0;
                        busy_o        <= 1'b1;
                        state         <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc + ACC_WD'(prod);
                    k   <= k + KW'(1);
                    if (k == KW'(HALF - 1)) begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    data_o       <= sat_round(ACC_MAX_WD'(acc), COEF_FRAC);
                    data_valid_o <= 1'b1;
                    state        <= OUT;
                end
                OUT: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sym_fir_serial.sv
// -----------------------------------------------------------------------------
// tb_sym_fir_serial
//   Directed bench for sym_fir_serial. Two instances share all inputs:
//   dut uses the production coefficients, dut_t the DC-gain-2 test set.
//   Expected production half-coefficients for TAPS=32 are the triangular
//   weights floor(65536*(k+1)/136), with the 8 LSB shortfall on h[15].
// -----------------------------------------------------------------------------
module tb_sym_fir_serial;

    logic        clk;
    logic        rst_n;
    logic [23:0] sample;
    logic        sample_valid;
    logic        clr_overrun;

    logic [23:0] data;
    logic        data_valid;
    logic        busy;
    logic        overrun;
    logic [23:0] t_data;
    logic        t_valid;
    logic        t_busy;
    logic        t_overrun;

    int total = 0;
    int bad   = 0;

    localparam int H [16] = '{481, 963, 1445, 1927, 2409, 2891, 3373, 3855,
                              4336, 4818, 5300, 5782, 6264, 6746, 7228, 7718};

    sym_fir_serial #(.TAPS(32), .DATA_WD(24), .COEF_SEL(0)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .sample_i       (sample),
        .sample_valid_i (sample_valid),
        .data_o         (data),
        .data_valid_o   (data_valid),
        .busy_o         (busy),
        .overrun_o      (overrun),
        .clr_overrun_i  (clr_overrun)
    );

    sym_fir_serial #(.TAPS(32), .DATA_WD(24), .COEF_SEL(1)) dut_t (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .sample_i       (sample),
        .sample_valid_i (sample_valid),
        .data_o         (t_data),
        .data_valid_o   (t_valid),
        .busy_o         (t_busy),
        .overrun_o      (t_overrun),
        .clr_overrun_i  (clr_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strobe one sample and wait for the result. lat counts cycles from the
    // accept cycle (0) to the cycle where data_valid is seen. A non-zero
    // dup_at re-strobes 0x7FFFFF in that cycle (optionally with a clear) and
    // checks the sticky overrun flag one cycle later. Returns in an idle cycle.
    task automatic feed(input logic [23:0] s, input int dup_at, input logic dup_clr,
                        output logic [23:0] d, output logic [23:0] dt, output int lat);
        sample       = s;
        sample_valid = 1'b1;
        tick;
        sample_valid = 1'b0;
        sample       = '0;
        lat = 1;
        while (data_valid !== 1'b1 && lat < 60) begin
            if (lat == dup_at) begin
                sample       = 24'h7FFFFF;
                sample_valid = 1'b1;
                clr_overrun  = dup_clr;
            end
            tick;
            sample_valid = 1'b0;
            clr_overrun  = 1'b0;
            sample       = '0;
            lat++;
            if (dup_at != 0 && lat == dup_at + 1) begin
                chk("overrun_set", 48'(overrun), 48'(1));
            end
        end
        d  = data;
        dt = t_data;
        tick;
    endtask

    initial begin
        logic [23:0] d;
        logic [23:0] dt;
        logic [23:0] u;
        int          lat;
        int          seen;
        longint      hist [32];
        longint      acc;
        longint      r;
        int          ex;

        rst_n        = 1'b0;
        sample       = '0;
        sample_valid = 1'b0;
        clr_overrun  = 1'b0;
        repeat (3) tick;

        // reset state
        chk("rst_data",    48'(data),       48'(0));
        chk("rst_valid",   48'(data_valid), 48'(0));
        chk("rst_busy",    48'(busy),       48'(0));
        chk("rst_overrun", 48'(overrun),    48'(0));
        rst_n = 1'b1;
        tick;

        // impulse response: h[0..15] then h[15..0], 18-cycle latency
        for (int n = 0; n < 32; n++) begin
            feed((n == 0) ? 24'h020000 : 24'h000000, 0, 1'b0, d, dt, lat);
            ex = (n < 16) ? H[n] : H[31-n];
            chk($sformatf("imp%0d", n), 48'(d), 48'(ex));
            chk($sformatf("imp_lat%0d", n), 48'(lat), 48'(18));
            if (n == 0) begin
                chk("valid_one_cycle", 48'(data_valid), 48'(0));
            end
        end

        // overrun: the dropped 0x7FFFFF must not reach the delay line
        feed(24'h020000, 5, 1'b0, d, dt, lat);
        chk("ovr_h0", 48'(d), 48'(H[0]));
        feed(24'h000000, 5, 1'b1, d, dt, lat);   // clear + new overrun: set wins
        chk("ovr_h1", 48'(d), 48'(H[1]));
        clr_overrun = 1'b1;
        tick;
        clr_overrun = 1'b0;
        chk("ovr_clr", 48'(overrun), 48'(0));
        feed(24'h000000, 0, 1'b0, d, dt, lat);
        chk("ovr_h2", 48'(d), 48'(H[2]));

        // reset mid-computation
        sample       = 24'h020000;
        sample_valid = 1'b1;
        tick;
        sample_valid = 1'b0;
        sample       = '0;
        chk("mid_busy", 48'(busy), 48'(1));
        repeat (2) tick;
        sample_valid = 1'b1;
        tick;
        sample_valid = 1'b0;
        chk("mid_ovr", 48'(overrun), 48'(1));
        repeat (4) tick;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_data",    48'(data),    48'(0));
        chk("mid_rst_busy",    48'(busy),    48'(0));
        chk("mid_rst_overrun", 48'(overrun), 48'(0));
        seen = 0;
        repeat (3) begin
            tick;
            if (data_valid === 1'b1 || t_valid === 1'b1) seen++;
        end
        rst_n = 1'b1;
        repeat (25) begin
            tick;
            if (data_valid === 1'b1 || t_valid === 1'b1) seen++;
        end
        chk("mid_no_valid", 48'(seen), 48'(0));
        chk("mid_data_zero", 48'(data), 48'(0));
        feed(24'h020000, 0, 1'b0, d, dt, lat);
        chk("post_rst_h0", 48'(d), 48'(H[0]));
        chk("post_rst_lat", 48'(lat), 48'(18));
        feed(24'h000000, 0, 1'b0, d, dt, lat);
        chk("post_rst_h1", 48'(d), 48'(H[1]));

        // DC step: unity gain once the line is full
        for (int n = 1; n <= 40; n++) begin
            feed(24'h100000, 0, 1'b0, d, dt, lat);
            if (n >= 32) begin
                chk($sformatf("dc%0d", n), 48'(d), 48'(24'h100000));
            end
        end

        // random samples against a direct-form convolution model
        for (int i = 0; i < 32; i++) hist[i] = 64'sh100000;
        for (int n = 0; n < 100; n++) begin
            u = 24'($urandom);
            for (int i = 31; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = longint'($signed(u));
            acc = 0;
            for (int i = 0; i < 32; i++) begin
                acc += hist[i] * longint'((i < 16) ? H[i] : H[31-i]);
            end
            r = (acc + 65536) >>> 17;
            if (r > 64'sd8388607)  r = 64'sd8388607;
            if (r < -64'sd8388608) r = -64'sd8388608;
            feed(u, 0, 1'b0, d, dt, lat);
            chk($sformatf("rand%0d", n), 48'(d), 48'(r[23:0]));
        end

        // saturation on the gain-2 instance
        for (int n = 1; n <= 32; n++) begin
            feed(24'h7FFFFF, 0, 1'b0, d, dt, lat);
        end
        chk("sat_pos_t", 48'(dt), 48'(24'h7FFFFF));
        chk("sat_pos_unity", 48'(d), 48'(24'h7FFFFF));
        for (int n = 1; n <= 32; n++) begin
            feed(24'h800000, 0, 1'b0, d, dt, lat);
            if (n == 20) begin
                // 20 of 32 taps negative: -2^22 - 0.25 LSB, floors to 0xBFFFFF
                chk("sat_mid_neg_t", 48'(dt), 48'(24'hBFFFFF));
            end
        end
        chk("sat_neg_t", 48'(dt), 48'(24'h800000));
        chk("sat_neg_unity", 48'(d), 48'(24'h800000));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
